// File: rtl/rr_arb_mux_pkg.sv
// Shared types and limits for the round-robin arbitrating mux.
// The lock-state enum is used only when RR_ARB_MUX_LOCK_EN is defined.
package rr_arb_mux_pkg;

  localparam int N_IN_MAX = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

endpackage

// File: rtl/rr_arb_mux_if.sv
// Handshake bundle between N_IN producers, the arbitrating mux and one consumer.
// slave is the mux side; master is the traffic (producer/consumer) side.
interface rr_arb_mux_if #(
  parameter int WIDTH = 32,
  parameter int N_IN  = 4,
  parameter int SEL_W = $clog2(N_IN)
);
  logic [N_IN-1:0]       in_valid;
  logic [N_IN*WIDTH-1:0] in_data;
  logic [N_IN-1:0]       in_last;
  logic [N_IN-1:0]       in_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_sel;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin grant: first requester at or above i_ptr, wrapping around.
// Purely combinational; produces a one-hot grant and its binary index.
module rr_arbiter #(
  parameter int N_IN  = 4,
  parameter int SEL_W = $clog2(N_IN)
) (
  input  logic [SEL_W-1:0] i_ptr,
  input  logic [N_IN-1:0]  i_valid,
  output logic [N_IN-1:0]  o_grant,
  output logic [SEL_W-1:0] o_idx,
  output logic             o_any
);

  int w_cand;

  always_comb begin
    // NOTE: every output gets a default before the search loop so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = 0;
    for (int k = 0; k < N_IN; k++) begin
      w_cand = int'(i_ptr) + k;
      if (w_cand >= N_IN) w_cand = w_cand - N_IN;
      if (!o_any && i_valid[w_cand]) begin
        o_any            = 1'b1;
        o_grant[w_cand]  = 1'b1;
        o_idx            = SEL_W'(w_cand);
      end
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// Round-robin N_IN:1 mux with a single registered output stage (1-cycle latency).
// Define RR_ARB_MUX_LOCK_EN to hold the grant on one channel until in_last.
module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N_IN  = 4,
  parameter int SEL_W = $clog2(N_IN)
) (
  input logic         clk,
  input logic         rst_n,
  rr_arb_mux_if.slave bus
);

  if (N_IN < 2 || N_IN > N_IN_MAX) begin : g_bad_n_in
    $error("rr_arb_mux: N_IN out of range");
  end

  logic [SEL_W-1:0] r_ptr;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_sel;

  logic [N_IN-1:0]  w_arb_valid;
  logic [N_IN-1:0]  w_grant;
  logic [SEL_W-1:0] w_idx;
  logic [SEL_W-1:0] w_next_ptr;
  logic             w_any;
  logic             w_load;
  logic             w_in_xfer;
  logic             w_ptr_adv;
  logic [WIDTH-1:0] w_sel_data;

  rr_arbiter #(
    .N_IN  (N_IN),
    .SEL_W (SEL_W)
  ) u_arbiter (
    .i_ptr   (r_ptr),
    .i_valid (w_arb_valid),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // The output register can take a beat when empty or draining this cycle.
  assign w_load       = ~r_out_valid | bus.out_ready;
  assign w_in_xfer    = rst_n & w_load & w_any;
  assign bus.in_ready = (rst_n & w_load) ? w_grant : '0;
  assign w_next_ptr   = (w_idx == SEL_W'(N_IN - 1)) ? '0 : w_idx + 1'b1;

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (w_grant[i]) w_sel_data = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

`ifdef RR_ARB_MUX_LOCK_EN
  lock_state_t      r_lock_state;
  logic [SEL_W-1:0] r_lock_ch;
  logic [N_IN-1:0]  w_lock_mask;

  assign w_lock_mask = {{(N_IN-1){1'b0}}, 1'b1} << r_lock_ch;
  assign w_arb_valid = (r_lock_state == LOCKED) ? (bus.in_valid & w_lock_mask)
                                                : bus.in_valid;
  // ptr only moves once a burst (or a single last-flagged beat) completes.
  assign w_ptr_adv   = bus.in_last[w_idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lock_state <= IDLE;
      r_lock_ch    <= '0;
    end else if (w_in_xfer) begin
      if (r_lock_state == IDLE) begin
        if (!bus.in_last[w_idx]) begin
          r_lock_state <= LOCKED;
          r_lock_ch    <= w_idx;
        end
      end else if (bus.in_last[w_idx]) begin
        r_lock_state <= IDLE;
      end
    end
  end
`else
  logic w_unused_last;

  assign w_unused_last = ^bus.in_last;
  assign w_arb_valid   = bus.in_valid;
  assign w_ptr_adv     = 1'b1;
`endif

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_ptr       <= '0;
    end else begin
      if (w_in_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sel_data;
        r_out_sel   <= w_idx;
        if (w_ptr_adv) r_ptr <= w_next_ptr;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_sel   = r_out_sel;

endmodule

// File: doc/rr_arb_mux.md
RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data bits per input channel.
REQ-002 SHALL have parameter N_IN, default 4, number of input channels (2..16).
REQ-003 SHALL have parameter SEL_W, default $clog2(N_IN), width of the grant index.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-006 SHALL have port in_valid  input  N_IN  per-channel request.
REQ-007 SHALL have port in_data  input  N_IN*WIDTH  channel i at bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port in_last  input  N_IN  per-channel end-of-burst flag; used only with lock enabled.
REQ-009 SHALL have port in_ready  output  N_IN  per-channel accept; at most one bit set.
REQ-010 SHALL have port out_valid  output  1  output register holds a beat.
REQ-011 SHALL have port out_ready  input  1  downstream accept.
REQ-012 SHALL have port out_data  output  WIDTH  registered selected data.
REQ-013 SHALL have port out_sel  output  SEL_W  index of the channel that supplied out_data.

Function
REQ-014 SHALL transfer on an input i when in_valid[i] and in_ready[i] are both high at a clk edge, and on the output when out_valid and out_ready are both high.
REQ-015 SHALL define load = ~out_valid | out_ready, and assert in_ready[i] only for the granted channel while load is high.
REQ-016 SHALL grant round-robin: search from channel ptr upward with wrap-around, and grant the first channel with in_valid set.
REQ-017 SHALL update ptr to (granted index + 1) mod N_IN on each input transfer, and leave ptr unchanged otherwise.
REQ-018 SHALL, on an input transfer, register in_data and the index into out_data/out_sel and set out_valid; latency is 1 cycle.
REQ-019 SHALL clear out_valid on an output transfer when no input transfer occurs in the same cycle.
REQ-020 SHALL sustain one beat per cycle when out_ready is held high, with simultaneous input and output transfer.
REQ-021 SHALL hold out_data/out_sel stable while out_valid & ~out_ready, with all in_ready low.
REQ-022 SHALL NOT let in_ready depend combinationally on in_data; in_ready depends only on in_valid, ptr, lock state and out_valid/out_ready.
REQ-023 SHALL assert no in_ready and leave ptr unchanged when no channel is valid.

Reset
REQ-024 SHALL, on a clk edge with rst_n low, set out_valid=0, out_data=0, out_sel=0, ptr=0 and lock state IDLE.
REQ-025 SHALL hold in_ready all-zero during reset.
REQ-026 SHALL discard any pending beat when reset is asserted mid-stream; no beat is replayed after reset.

Configuration
REQ-027 SHALL compile burst locking in when macro RR_ARB_MUX_LOCK_EN is defined.
REQ-028 SHALL, with RR_ARB_MUX_LOCK_EN, use a 2-state FSM:
  - IDLE -> LOCKED on a transfer with in_last=0, capturing the channel.
  - LOCKED grants only the captured channel and ignores all other channels.
  - LOCKED -> IDLE on a transfer of the captured channel with in_last=1; ptr advances then.
REQ-029 SHALL, without the macro, ignore in_last, contain no lock FSM, and arbitrate every beat independently.

Structure
REQ-030 SHALL place the lock-state enum (IDLE, LOCKED) and the N_IN upper-limit constant in the shared package rr_arb_mux_pkg.
REQ-031 SHALL implement grant computation (ptr, in_valid -> one-hot grant, index) in sub-module rr_arbiter; datapath, output register and FSM stay in rr_arb_mux.

Verification
REQ-032 SHALL cover: N_IN=4, all in_valid=1, out_ready=1, data[i]=32'h1000+i -> out_sel sequence 0,1,2,3,0 on consecutive cycles, first out_valid one cycle after the first transfer.
REQ-033 SHALL cover: only ch2 valid with data 32'hAABBCCDD -> in_ready=4'b0100, then out_data=32'hAABBCCDD and out_sel=2 next cycle.
REQ-034 SHALL cover: out_valid=1 with out_ready=0 for 3 cycles -> in_ready=0 and out_data stable; out_ready=1 -> next beat loads in the same cycle.
REQ-035 SHALL cover: rst_n=0 for one edge mid-stream -> out_valid=0 and ptr=0; the first grant after reset goes to ch0 when all channels are valid.
REQ-036 SHALL cover (RR_ARB_MUX_LOCK_EN): ch1 sends 3 beats with in_last=0,0,1 while ch0/ch3 are valid -> out_sel=1,1,1, then 2 if valid, else 3.
REQ-037 SHALL cover (macro off, same stimulus as REQ-036) -> out_sel alternates per beat round-robin.
